board_io_cond: RTL
==================

// Module: board_io_cond
// PURPOSE
//  Board-level input conditioner and activity indicator; sits between board pins and the MCU/LEDs.
//  Synchronises and debounces the push-buttons and emits single-cycle edge pulses.
//  Stretches short activity (UART rx/tx, SPI chip-select) into visible LED pulses.
//  Downstream consumers: LED drivers and MCU-side debug logic. Driven at 50 MHz from the PLL clock.
// PARAMETERS
//  NSW        4       number of switch channels
//  NACT       4       number of activity channels
//  DEBOUNCE_W 16      debounce counter width; stable time = 2^DEBOUNCE_W cycles (~1.3 ms)
//  STRETCH_W  22      stretch counter width; LED on-time = 2^STRETCH_W-1 cycles (~84 ms)
//  RST_SW     {NSW{1'b1}}   reset/idle level of switches (buttons are active-low)
//  ACT_IDLE   {NACT{1'b1}}  reset/idle level of activity inputs (UART, csn idle high)
// PORTS
//  clk       in   1     system clock, single domain
//  rst       in   1     synchronous reset, active-high
//  sw_raw    in   NSW   asynchronous raw button pins
//  act_in    in   NACT  asynchronous activity signals (uart_rx, uart_tx, spi_csn, spare)
//  sw_db     out  NSW   debounced switch levels
//  sw_rise   out  NSW   1-cycle pulse when sw_db goes 0->1
//  sw_fall   out  NSW   1-cycle pulse when sw_db goes 1->0
//  act_led   out  NACT  stretched activity, 1 = LED on
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): sync flops <= RST_SW / ACT_IDLE; all counters 0;
//   sw_db=RST_SW, sw_rise=sw_fall=0, act_led=0. Reset wins over every other event, incl. mid-count.
//  Sync: two flops per input (s1,s2); s2 is the only value used internally.
//  Debounce, per channel, independent:
//   - s2==sw_db: counter cleared to 0.
//   - s2!=sw_db and counter<2^DEBOUNCE_W-1: counter+1.
//   - s2!=sw_db and counter==all-ones: sw_db<=s2, counter<=0, matching edge pulse asserted next cycle only.
//   - Any agreeing cycle (bounce) restarts the count; no partial credit.
//   - Latency raw->sw_db = 2 (sync) + 2^DEBOUNCE_W cycles for a clean step.
//   - sw_rise/sw_fall registered, high exactly one cycle coincident with the sw_db change.
//  Activity stretch, per channel:
//   - third flop s3; edge = s2^s3 (either polarity).
//   - edge: counter <= 2^STRETCH_W-1 (retrigger reloads, never accumulates).
//   - else counter>0: counter-1; counter saturates at 0, no wrap.
//   - act_led = (counter!=0), registered; on for exactly 2^STRETCH_W-1 cycles after the last edge.
//   - edge and counter reaching 0 in the same cycle: reload wins.
//  Channels never interact; simultaneous events on multiple channels are handled in parallel.
// STRUCTURE
//  Sub-module io_debounce (one switch channel: sync, counter, level, pulses) generated NSW times.
//  Activity stretch implemented inline in a generate loop.
//  Shared header board_io_defs.vh: default widths, RST_SW/ACT_IDLE constants for this board.
//  Top instantiates it with rst = ~arst_n; act_in = {spi_csn, uart_tx, uart_rx, 1'b1}.
// TESTING (bench params: DEBOUNCE_W=3, STRETCH_W=4, NSW=NACT=4)
//  1 rst held 3 cycles, inputs idle -> sw_db=4'hF, sw_rise=sw_fall=0, act_led=0.
//  2 sw_raw[0] 1->0 held -> sw_db[0]=0 and sw_fall[0]=1 exactly 10 cycles after the step, pulse 1 cycle.
//  3 sw_raw[1] low 5 cycles then high -> sw_db[1] stays 1, no pulses.
//  4 act_in[2] single 1-cycle low glitch -> act_led[2] high 15 cycles; second edge mid-stretch reloads to 15.
//  5 rst asserted during stretch and mid-debounce -> act_led=0, sw_db=4'hF next cycle; counts restart.
//  6 sw_raw[2] and sw_raw[3] change on the same cycle -> both sw_db bits update on the same cycle.

Source files
------------

// File: rtl/board_io_cond_pkg.sv
// Shared types and board defaults for the button/activity conditioner.
// Imported by the debounce channel and the top.
package board_io_cond_pkg;

  localparam int NSW_DEF        = 4;
  localparam int NACT_DEF       = 4;
  localparam int DEBOUNCE_W_DEF = 16;
  localparam int STRETCH_W_DEF  = 22;

  // Activity bit positions as wired on the board.
  localparam int ACT_SPARE   = 0;
  localparam int ACT_UART_RX = 1;
  localparam int ACT_UART_TX = 2;
  localparam int ACT_SPI_CSN = 3;

  typedef struct packed {
    logic s1;
    logic s2;
    logic s3;
  } sync3_t;

  function automatic logic toggled(input sync3_t s);
    return s.s2 ^ s.s3;
  endfunction

endpackage

// File: rtl/board_io_cond_debounce.sv
// One switch channel: two-flop sync, stable-time counter,
// debounced level and registered edge pulses.
module io_debounce
  import board_io_cond_pkg::*;
#(
  parameter int   DEBOUNCE_W = DEBOUNCE_W_DEF,
  parameter logic RST_VAL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam logic [DEBOUNCE_W-1:0] ONE = 1;

  logic                  s1;
  logic                  s2;
  logic [DEBOUNCE_W-1:0] cnt;
  logic [DEBOUNCE_W-1:0] cnt_nxt;
  logic                  db_nxt;
  logic                  rise_nxt;
  logic                  fall_nxt;

  always_comb begin
    cnt_nxt  = '0;
    db_nxt   = db;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (s2 != db) begin
      if (cnt == '1) begin
        db_nxt   = s2;
        rise_nxt = s2;
        fall_nxt = ~s2;
      end else begin
        cnt_nxt = cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      cnt  <= '0;
      db   <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      cnt  <= cnt_nxt;
      db   <= db_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

endmodule

// File: rtl/board_io_cond.sv
// Board input conditioner: debounced buttons with edge pulses
// and LED stretching of short activity on UART/SPI lines.
module board_io_cond
  import board_io_cond_pkg::*;
#(
  parameter int NSW        = NSW_DEF,
  parameter int NACT       = NACT_DEF,
  parameter int DEBOUNCE_W = DEBOUNCE_W_DEF,
  parameter int STRETCH_W  = STRETCH_W_DEF,
  parameter logic [NSW-1:0]  RST_SW   = '1,
  parameter logic [NACT-1:0] ACT_IDLE = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSW-1:0]  sw_raw,
  input  logic [NACT-1:0] act_in,
  output logic [NSW-1:0]  sw_db,
  output logic [NSW-1:0]  sw_rise,
  output logic [NSW-1:0]  sw_fall,
  output logic [NACT-1:0] act_led
);

  localparam logic [STRETCH_W-1:0] ONE = 1;

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    io_debounce #(
      .DEBOUNCE_W (DEBOUNCE_W),
      .RST_VAL    (RST_SW[i])
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (sw_raw[i]),
      .db   (sw_db[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

  for (genvar j = 0; j < NACT; j++) begin : g_act
    sync3_t               sy;
    logic [STRETCH_W-1:0] cnt;
    logic [STRETCH_W-1:0] cnt_nxt;
    logic                 led;

    // A fresh edge always reloads, even on the cycle the count expires.
    always_comb begin
      cnt_nxt = cnt;
      if (toggled(sy)) begin
        cnt_nxt = '1;
      end else if (cnt != '0) begin
        cnt_nxt = cnt - ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sy  <= '{s1: ACT_IDLE[j], s2: ACT_IDLE[j], s3: ACT_IDLE[j]};
        cnt <= '0;
        led <= 1'b0;
      end else begin
        sy  <= '{s1: act_in[j], s2: sy.s1, s3: sy.s2};
        cnt <= cnt_nxt;
        led <= (cnt_nxt != '0);
      end
    end

    assign act_led[j] = led;
  end

endmodule
